// File: rtl/id_ex_skid_if.sv
// id_ex_skid_if: decode->execute valid/ready handshake and payload bundle
// master drives the decode side and ex_ready; slave is the skid pipe
interface id_ex_skid_if #(
  parameter int XLEN     = 64,
  parameter int RADDR_W  = 5,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3
);
  logic                id_valid;
  logic                id_ready;
  logic [ALUOP_W-1:0]  id_aluop;
  logic [ALUSEL_W-1:0] id_alusel;
  logic [XLEN-1:0]     id_reg1;
  logic [XLEN-1:0]     id_reg2;
  logic [RADDR_W-1:0]  id_w_rd_addr;
  logic                id_w_reg_e;
  logic                ex_valid;
  logic                ex_ready;
  logic [ALUOP_W-1:0]  ex_aluop;
  logic [ALUSEL_W-1:0] ex_alusel;
  logic [XLEN-1:0]     ex_reg1;
  logic [XLEN-1:0]     ex_reg2;
  logic [RADDR_W-1:0]  ex_w_rd_addr;
  logic                ex_w_reg_e;
  modport master (
    output id_valid, id_aluop, id_alusel, id_reg1, id_reg2, id_w_rd_addr, id_w_reg_e, ex_ready,
    input  id_ready, ex_valid, ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_w_rd_addr, ex_w_reg_e
  );
  modport slave (
    input  id_valid, id_aluop, id_alusel, id_reg1, id_reg2, id_w_rd_addr, id_w_reg_e, ex_ready,
    output id_ready, ex_valid, ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_w_rd_addr, ex_w_reg_e
  );
endinterface

// File: rtl/id_ex_skid_pipe.sv
// id_ex_skid_pipe: 2-entry ID->EX skid buffer with flush, x0 write suppression and stall counter
// ports: clk, rst (sync, active-low), flush, bus (id_*/ex_* handshake + payload), stall_cnt
module id_ex_skid_pipe #(
  parameter int XLEN        = 64,
  parameter int RADDR_W     = 5,
  parameter int ALUOP_W     = 8,
  parameter int ALUSEL_W    = 3,
  parameter int STALL_CNT_W = 16,
  parameter logic [ALUOP_W-1:0]  NOP_ALUOP  = '0,
  parameter logic [ALUSEL_W-1:0] NOP_ALUSEL = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  id_ex_skid_if.slave            bus,
  output logic [STALL_CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  typedef struct packed {
    logic [ALUOP_W-1:0]  aluop;
    logic [ALUSEL_W-1:0] alusel;
    logic [XLEN-1:0]     reg1;
    logic [XLEN-1:0]     reg2;
    logic [RADDR_W-1:0]  rd;
    logic                we;
  } pl_t;
  localparam pl_t BUBBLE = '{aluop: NOP_ALUOP, alusel: NOP_ALUSEL, reg1: '0, reg2: '0, rd: '0, we: 1'b0};
  state_t state;
  pl_t main_q, skid_q, in_pl;
  logic accept, pop;
  // writes to x0 are dropped at capture so execute never sees them enabled
  assign in_pl = '{aluop: bus.id_aluop, alusel: bus.id_alusel, reg1: bus.id_reg1, reg2: bus.id_reg2,
                   rd: bus.id_w_rd_addr, we: bus.id_w_reg_e && |bus.id_w_rd_addr};
  // ready depends only on registered state, never on ex_ready
  assign bus.id_ready     = rst && state != FULL;
  assign bus.ex_valid     = state != EMPTY;
  assign accept           = bus.id_valid && bus.id_ready;
  assign pop              = bus.ex_valid && bus.ex_ready;
  assign bus.ex_aluop     = main_q.aluop;
  assign bus.ex_alusel    = main_q.alusel;
  assign bus.ex_reg1      = main_q.reg1;
  assign bus.ex_reg2      = main_q.reg2;
  assign bus.ex_w_rd_addr = main_q.rd;
  assign bus.ex_w_reg_e   = main_q.we;
  // main reg is reloaded with BUBBLE whenever the buffer empties so ex_* are plain register outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= EMPTY;
      main_q    <= BUBBLE;
      skid_q    <= BUBBLE;
      stall_cnt <= '0;
    end else begin
      if (bus.ex_valid && !bus.ex_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (flush) begin
        state  <= EMPTY;
        main_q <= BUBBLE;
      end else begin
        case (state)
          EMPTY: if (accept) begin
            state  <= ONE;
            main_q <= in_pl;
          end
          ONE: if (accept && pop) main_q <= in_pl;
          else if (accept) begin
            state  <= FULL;
            skid_q <= in_pl;
          end else if (pop) begin
            state  <= EMPTY;
            main_q <= BUBBLE;
          end
          FULL: if (pop) begin
            state  <= ONE;
            main_q <= skid_q;
          end
          default: begin
            state  <= EMPTY;
            main_q <= BUBBLE;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_id_ex_skid_pipe.sv
// tb_id_ex_skid_pipe: directed self-checking bench for id_ex_skid_pipe
module tb_id_ex_skid_pipe;
  logic clk = 0;
  logic rst = 0;
  logic flush = 0;
  logic [3:0] stall_cnt;
  int tests = 0;
  int fails = 0;
  id_ex_skid_if bus();
  id_ex_skid_pipe #(.STALL_CNT_W(4)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus), .stall_cnt(stall_cnt));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [63:0] r1, input logic [4:0] rd, input logic we);
    bus.id_valid     = v;
    bus.id_aluop     = 8'h11;
    bus.id_alusel    = 3'b100;
    bus.id_reg1      = r1;
    bus.id_reg2      = 64'h0;
    bus.id_w_rd_addr = rd;
    bus.id_w_reg_e   = we;
  endtask
  initial begin
    bus.ex_ready = 1'b0;
    drive(1'b1, 64'h5, 5'd1, 1'b1);
    step();
    chk("rst_id_ready", bus.id_ready, 0);
    step();
    step();
    chk("rst_ex_valid", bus.ex_valid, 0);
    chk("rst_id_ready2", bus.id_ready, 0);
    chk("rst_we", bus.ex_w_reg_e, 0);
    chk("rst_aluop", bus.ex_aluop, 0);
    chk("rst_stall", stall_cnt, 0);
    drive(1'b0, 64'h0, 5'd0, 1'b0);
    rst = 1'b1;
    step();
    chk("post_rst_ready", bus.id_ready, 1);
    chk("post_rst_valid", bus.ex_valid, 0);
    bus.ex_ready = 1'b1;
    drive(1'b1, 64'h5, 5'd1, 1'b1);
    step();
    chk("pt_a_valid", bus.ex_valid, 1);
    chk("pt_a_reg1", bus.ex_reg1, 64'h5);
    chk("pt_a_rd", bus.ex_w_rd_addr, 1);
    chk("pt_a_aluop", bus.ex_aluop, 8'h11);
    chk("pt_a_we", bus.ex_w_reg_e, 1);
    drive(1'b1, 64'h6, 5'd2, 1'b1);
    step();
    chk("pt_b_rd", bus.ex_w_rd_addr, 2);
    chk("pt_b_ready", bus.id_ready, 1);
    drive(1'b1, 64'h7, 5'd3, 1'b1);
    step();
    chk("pt_c_rd", bus.ex_w_rd_addr, 3);
    chk("pt_c_reg1", bus.ex_reg1, 64'h7);
    drive(1'b0, 64'h0, 5'd0, 1'b0);
    step();
    chk("pt_bubble_valid", bus.ex_valid, 0);
    chk("pt_bubble_aluop", bus.ex_aluop, 0);
    chk("pt_bubble_we", bus.ex_w_reg_e, 0);
    chk("pt_stall", stall_cnt, 0);
    bus.ex_ready = 1'b0;
    drive(1'b1, 64'h5, 5'd1, 1'b1);
    step();
    chk("bp_a_valid", bus.ex_valid, 1);
    chk("bp_ready1", bus.id_ready, 1);
    drive(1'b1, 64'h6, 5'd2, 1'b1);
    step();
    chk("bp_ready_full", bus.id_ready, 0);
    chk("bp_hold_a", bus.ex_w_rd_addr, 1);
    chk("bp_stall1", stall_cnt, 1);
    drive(1'b1, 64'h7, 5'd3, 1'b1);
    step();
    chk("bp_stall2", stall_cnt, 2);
    chk("bp_hold_a2", bus.ex_reg1, 64'h5);
    drive(1'b0, 64'h0, 5'd0, 1'b0);
    bus.ex_ready = 1'b1;
    step();
    chk("bp_pop_b", bus.ex_w_rd_addr, 2);
    chk("bp_pop_b_reg1", bus.ex_reg1, 64'h6);
    chk("bp_ready_back", bus.id_ready, 1);
    chk("bp_stall_hold", stall_cnt, 2);
    step();
    chk("bp_empty", bus.ex_valid, 0);
    bus.ex_ready = 1'b0;
    drive(1'b1, 64'h5, 5'd1, 1'b1);
    step();
    drive(1'b1, 64'h6, 5'd2, 1'b1);
    step();
    chk("fl_full", bus.id_ready, 0);
    chk("fl_stall3", stall_cnt, 3);
    drive(1'b1, 64'h7, 5'd3, 1'b1);
    flush = 1'b1;
    step();
    chk("fl_valid", bus.ex_valid, 0);
    chk("fl_ready", bus.id_ready, 1);
    chk("fl_stall4", stall_cnt, 4);
    flush = 1'b0;
    drive(1'b0, 64'h0, 5'd0, 1'b0);
    step();
    chk("fl_c_dropped", bus.ex_valid, 0);
    bus.ex_ready = 1'b1;
    drive(1'b1, 64'h1234, 5'd0, 1'b1);
    step();
    chk("x0_valid", bus.ex_valid, 1);
    chk("x0_we", bus.ex_w_reg_e, 0);
    chk("x0_reg1", bus.ex_reg1, 64'h1234);
    chk("x0_rd", bus.ex_w_rd_addr, 0);
    drive(1'b0, 64'h0, 5'd0, 1'b0);
    step();
    rst = 1'b0;
    step();
    chk("rst2_stall", stall_cnt, 0);
    rst = 1'b1;
    bus.ex_ready = 1'b0;
    drive(1'b1, 64'h9, 5'd4, 1'b1);
    step();
    drive(1'b0, 64'h0, 5'd0, 1'b0);
    for (int i = 0; i < 14; i++) step();
    chk("sat_14", stall_cnt, 4'hE);
    for (int i = 0; i < 6; i++) step();
    chk("sat_hold", stall_cnt, 4'hF);
    chk("sat_payload", bus.ex_w_rd_addr, 4);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("sat_after_flush", stall_cnt, 4'hF);
    chk("sat_flush_valid", bus.ex_valid, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
